fpaddsub_norm_shift_stage: RTL and testbench
============================================

// Module: fpaddsub_norm_shift_stage
// PURPOSE
//   Normalisation stage that consumes the leading-nought count of the FP add/sub
//   mantissa sum. Left-shifts the 26-bit sum so its leading one lands at bit 25
//   and adjusts the exponent to match. Detects a zero result and exponent
//   underflow. Two-stage registered pipeline with valid/ready handshakes on both
//   sides; sits between the leading-nought counter and the rounding stage.
// PARAMETERS
//   MANT_W  26  mantissa-sum width; leading one normalised to bit MANT_W-1
//   EXP_W   8   biased exponent width
//   LNC_W   5   leading-nought count width (count range 0..MANT_W)
// PORTS
//   clk        in   1       single clock, all state on rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       upstream word valid
//   in_ready   out  1       stage can accept a word this cycle
//   in_mant    in   MANT_W  unnormalised mantissa sum
//   in_lnc     in   LNC_W   leading-nought count of in_mant (MANT_W means all zero)
//   in_exp     in   EXP_W   biased exponent of the bit-25 position of in_mant
//   in_sign    in   1       result sign
//   out_valid  out  1       normalised word valid
//   out_ready  in   1       downstream accepts word
//   out_mant   out  MANT_W  normalised mantissa
//   out_exp    out  EXP_W   adjusted biased exponent
//   out_sign   out  1       sign, passed through (forced 0 on zero result)
//   out_zero   out  1       result is exactly zero
//   out_uf     out  1       exponent underflow occurred (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all outputs 0; both stage valid bits 0; in_ready=1 during the cycle
//     after reset deasserts.
//   - Transfer occurs when valid&&ready on a port in the same cycle.
//   - S1 registers {in_mant, in_lnc, in_exp, in_sign}. S2 registers the shifted
//     result. Latency: 2 cycles from input transfer to out_valid when unstalled.
//   - Throughput: 1 word/cycle. adv2 = !s2_valid || out_ready;
//     adv1 = !s1_valid || adv2; in_ready = adv1 (combinational, no skid buffer).
//   - Stall: while out_valid && !out_ready, S2 holds all outputs stable. S1
//     holds its word. in_ready=0 only when both stages are full and stalled.
//   - Bubbles collapse: an empty S2 accepts from S1 regardless of out_ready.
//   - in_lnc > MANT_W is treated as MANT_W.
//   - Zero (lnc==MANT_W): out_mant=0, out_exp=0, out_sign=0, out_zero=1, out_uf=0.
//   - Normal (in_exp > lnc): out_mant = in_mant << lnc; out_exp = in_exp - lnc;
//     out_uf=0.
//   - Underflow (in_exp <= lnc, nonzero): handled per CONFIGURATION.
//   - Exponent arithmetic is done at EXP_W+1 bits; in_exp=0 is always underflow.
//   - Synchronous rst mid-operation: both words are discarded and outputs return
//     to 0 on the next edge. No partial word is emitted.
// CONFIGURATION
//   FPADDSUB_NORM_FTZ_EN defined: underflow flushes to zero:
//     out_mant=0, out_exp=0, out_zero=1, out_uf=1, sign kept.
//   FPADDSUB_NORM_FTZ_EN undefined: gradual underflow. The shift amount is
//     (in_exp==0 ? 0 : in_exp-1); out_exp=0; out_zero=0; out_uf=1 if any nonzero
//     bit is shifted into or beyond the leading-one position short of bit 25,
//     i.e. out_mant[25]==0.
// TESTING
//   1 in_mant=26'h2000000, lnc=0, exp=8'd127, sign=1 -> after 2 cycles
//     out_mant=26'h2000000, out_exp=127, out_sign=1, zero=0, uf=0.
//   2 in_mant=26'h0000100, lnc=17, exp=8'd130 -> out_mant=26'h2000000,
//     out_exp=113, uf=0.
//   3 in_mant=0, lnc=26, exp=8'd90, sign=1 -> out_mant=0, out_exp=0, out_sign=0,
//     out_zero=1.
//   4 in_mant=26'h0000400, lnc=15, exp=8'd5 -> FTZ_EN: mant=0, exp=0, zero=1,
//     uf=1; no FTZ_EN: mant=26'h0004000 (<<4), exp=0, uf=1.
//   5 Stream 8 back-to-back words with out_ready low for cycles 3-6 ->
//     in_ready drops once S1 and S2 are both full; all 8 words emerge in order,
//     none lost or duplicated, outputs stable while stalled.
//   6 Assert rst for 1 cycle with both stages full -> next cycle out_valid=0,
//     all outputs 0, in_ready=1.

Source files
------------

// File: rtl/fpaddsub_norm_shift_stage.sv
`default_nettype none
// ============================================================================
// Module  : fpaddsub_norm_shift_stage
// Brief   : FP add/sub normalisation stage. Left-shifts the mantissa sum by its
//           leading-nought count, adjusts the exponent, flags zero/underflow.
//           Two registered stages with valid/ready on both sides.
//           Macro FPADDSUB_NORM_FTZ_EN selects flush-to-zero on underflow;
//           when undefined, underflow is gradual (denormal result).
// Rev     : 1.0  initial release
// ============================================================================
module fpaddsub_norm_shift_stage #(
  parameter int MANT_W = 26,
  parameter int EXP_W  = 8,
  parameter int LNC_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [LNC_W-1:0]  in_lnc,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_uf
);

  localparam logic [LNC_W-1:0] c_lnc_max = LNC_W'(MANT_W);

  logic              r_s1_valid;
  logic [MANT_W-1:0] r_s1_mant;
  logic [LNC_W-1:0]  r_s1_lnc;
  logic [EXP_W-1:0]  r_s1_exp;
  logic              r_s1_sign;

  logic              r_s2_valid;
  logic [MANT_W-1:0] r_s2_mant;
  logic [EXP_W-1:0]  r_s2_exp;
  logic              r_s2_sign;
  logic              r_s2_zero;
  logic              r_s2_uf;

  logic              w_adv1;
  logic              w_adv2;
  logic [LNC_W-1:0]  w_lnc_sat;
  logic [EXP_W:0]    w_exp_ext;
  logic [EXP_W:0]    w_lnc_ext;
  logic              w_is_zero;
  logic              w_is_normal;
  logic [MANT_W-1:0] w_uf_mant;
  logic              w_uf_zero;
  logic              w_uf_flag;
  logic [MANT_W-1:0] w_mant;
  logic [EXP_W-1:0]  w_exp;
  logic              w_sign;
  logic              w_zero;
  logic              w_uf;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  // Counts beyond the word width mean the same thing as an all-zero sum.
  assign w_lnc_sat   = (r_s1_lnc > c_lnc_max) ? c_lnc_max : r_s1_lnc;
  assign w_exp_ext   = {1'b0, r_s1_exp};
  assign w_lnc_ext   = (EXP_W+1)'(w_lnc_sat);
  assign w_is_zero   = (w_lnc_sat == c_lnc_max);
  assign w_is_normal = (w_exp_ext > w_lnc_ext);

`ifdef FPADDSUB_NORM_FTZ_EN
  assign w_uf_mant = '0;
  assign w_uf_zero = 1'b1;
  assign w_uf_flag = 1'b1;
`else
  // Denormal: shift only as far as the exponent allows, exponent pinned at 0.
  logic [EXP_W-1:0] w_uf_shamt;
  assign w_uf_shamt = (r_s1_exp == '0) ? '0 : (r_s1_exp - EXP_W'(1));
  assign w_uf_mant  = r_s1_mant << w_uf_shamt;
  assign w_uf_zero  = 1'b0;
  assign w_uf_flag  = !w_uf_mant[MANT_W-1];
`endif

  always_comb begin
    w_mant = '0;
    w_exp  = '0;
    w_sign = 1'b0;
    w_zero = 1'b0;
    w_uf   = 1'b0;
    if (w_is_zero) begin
      w_zero = 1'b1;
    end else if (w_is_normal) begin
      w_mant = r_s1_mant << w_lnc_sat;
      w_exp  = r_s1_exp - EXP_W'(w_lnc_sat);
      w_sign = r_s1_sign;
    end else begin
      w_mant = w_uf_mant;
      w_sign = r_s1_sign;
      w_zero = w_uf_zero;
      w_uf   = w_uf_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_lnc   <= '0;
      r_s1_exp   <= '0;
      r_s1_sign  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_mant  <= '0;
      r_s2_exp   <= '0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_uf    <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_mant <= in_mant;
          r_s1_lnc  <= in_lnc;
          r_s1_exp  <= in_exp;
          r_s1_sign <= in_sign;
        end
      end
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_mant <= w_mant;
          r_s2_exp  <= w_exp;
          r_s2_sign <= w_sign;
          r_s2_zero <= w_zero;
          r_s2_uf   <= w_uf;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_mant  = r_s2_mant;
  assign out_exp   = r_s2_exp;
  assign out_sign  = r_s2_sign;
  assign out_zero  = r_s2_zero;
  assign out_uf    = r_s2_uf;

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_norm_shift_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpaddsub_norm_shift_stage
// Brief   : Self-checking bench: directed vectors, stall stream, reset flush,
//           randomized traffic against a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fpaddsub_norm_shift_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] in_mant = '0;
  logic [4:0]  in_lnc = '0;
  logic [7:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_zero;
  logic        out_uf;

  int total = 0;
  int bad   = 0;

  logic [36:0] q[$];
  logic [37:0] hold_word;
  logic        hold_valid = 1'b0;
  logic        in_xfer;
  logic        saw_backpressure;
  int          n_out;

  fpaddsub_norm_shift_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_lnc(in_lnc), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_uf(out_uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Result packed as {mant, exp, sign, zero, uf}.
  function automatic logic [36:0] model(logic [25:0] m, int lnc, int e, logic s);
    int sh;
    if (lnc > 26) lnc = 26;
    if (lnc == 26) return {26'd0, 8'd0, 1'b0, 1'b1, 1'b0};
    if (e > lnc) return {26'(m << lnc), 8'(e - lnc), s, 1'b0, 1'b0};
`ifdef FPADDSUB_NORM_FTZ_EN
    sh = 0;
    return {26'd0, 8'(sh), s, 1'b1, 1'b1};
`else
    sh = (e == 0) ? 0 : e - 1;
    return {26'(m << sh), 8'd0, s, 1'b0, logic'(sh != lnc)};
`endif
  endfunction

  function automatic logic [36:0] outs();
    return {out_mant, out_exp, out_sign, out_zero, out_uf};
  endfunction

  task automatic gen_word();
    int lz;
    logic [25:0] m;
    lz = $urandom_range(0, 26);
    m = '0;
    if (lz < 26) begin
      m[25-lz] = 1'b1;
      for (int b = 0; b < 25 - lz; b++) m[b] = 1'($urandom);
    end
    in_mant = m;
    in_lnc  = 5'(lz);
    if (lz == 26 && ($urandom % 4) == 0) in_lnc = 5'($urandom_range(27, 31));
    in_exp  = ($urandom % 2) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
    in_sign = 1'($urandom);
  endtask

  // One clock of monitored traffic; inputs are set by the caller beforehand.
  task automatic cycle();
    @(negedge clk);
    in_xfer = in_valid && in_ready;
    if (in_xfer) q.push_back(model(in_mant, int'(in_lnc), int'(in_exp), in_sign));
    if (!in_ready) saw_backpressure = 1'b1;
    if (hold_valid) chk("stall_stable", {out_valid, outs()}, hold_word);
    hold_valid = 1'b0;
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) chk("unexpected_word", 1, 0);
      else chk("stream_word", outs(), q.pop_front());
    end else if (out_valid) begin
      hold_valid = 1'b1;
      hold_word  = {out_valid, outs()};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    hold_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", outs(), 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string t, input logic [25:0] m, input logic [4:0] l,
                          input logic [7:0] e, input logic s, input logic [36:0] expv);
    in_mant = m; in_lnc = l; in_exp = e; in_sign = s;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({t, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({t, "_not_yet"}, out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({t, "_valid"}, out_valid, 1);
    chk({t, "_data"}, outs(), expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int c;
    do_reset();

    send_one("t1", 26'h2000000, 5'd0, 8'd127, 1'b1, {26'h2000000, 8'd127, 1'b1, 1'b0, 1'b0});
    send_one("t2", 26'h0000100, 5'd17, 8'd130, 1'b0, {26'h2000000, 8'd113, 1'b0, 1'b0, 1'b0});
    send_one("t3", 26'h0000000, 5'd26, 8'd90, 1'b1, {26'h0, 8'd0, 1'b0, 1'b1, 1'b0});
    send_one("t3b", 26'h0000000, 5'd31, 8'd12, 1'b1, {26'h0, 8'd0, 1'b0, 1'b1, 1'b0});
`ifdef FPADDSUB_NORM_FTZ_EN
    send_one("t4", 26'h0000400, 5'd15, 8'd5, 1'b1, {26'h0, 8'd0, 1'b1, 1'b1, 1'b1});
    send_one("t4z", 26'h2000000, 5'd0, 8'd0, 1'b0, {26'h0, 8'd0, 1'b0, 1'b1, 1'b1});
`else
    send_one("t4", 26'h0000400, 5'd15, 8'd5, 1'b1, {26'h0004000, 8'd0, 1'b1, 1'b0, 1'b1});
    send_one("t4z", 26'h2000000, 5'd0, 8'd0, 1'b0, {26'h2000000, 8'd0, 1'b0, 1'b0, 1'b0});
`endif

    // Eight back-to-back words with the sink stalled for cycles 3..6.
    sent = 0; c = 0; n_out = 0; saw_backpressure = 1'b0;
    gen_word();
    while ((sent < 8 || q.size() > 0) && c < 100) begin
      in_valid  = (sent < 8);
      out_ready = !(c >= 3 && c <= 6);
      cycle();
      if (in_xfer) begin sent++; gen_word(); end
      c++;
    end
    chk("t5_count", n_out, 8);
    chk("t5_backpressure", saw_backpressure, 1);
    chk("t5_drained", q.size(), 0);

    // Fill both stages while stalled, then reset.
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) begin
      gen_word();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t6_full_in_ready", in_ready, 0);
    chk("t6_full_out_valid", out_valid, 1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_outputs", outs(), 0);
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    q.delete(); hold_valid = 1'b0;

    // Randomized traffic with random stalls.
    n_out = 0;
    gen_word();
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid) gen_word();
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      cycle();
      if (in_xfer) begin gen_word(); in_valid = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    c = 0;
    while (q.size() > 0 && c < 50) begin cycle(); c++; end
    chk("rand_drained", q.size(), 0);
    chk("rand_activity", n_out > 500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
